// File: rtl/test_pattern_gen.sv
// Multi-lane serial test pattern generator: fixed pattern, walking one and optional PRBS7/PRBS15.
// PRBS modes and the LANE_INV mask are built only when TEST_PATTERN_GEN_PRBS_EN is defined.
module test_pattern_gen #(
   parameter int               LANES    = 4,
   parameter int               PAT_W    = 32,
   parameter logic [LANES-1:0] LANE_INV = '0
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             enable,
   input  logic             load,
   input  logic [1:0]       mode,
   input  logic [PAT_W-1:0] pattern,
   output logic [LANES-1:0] serial_out,
   output logic             frame_start,
   output logic             busy
);
   localparam int CW = $clog2(PAT_W);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_STOP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_sh_mode;
   logic [1:0]       r_act_mode;
   logic [1:0]       w_sh_mode;
   logic [1:0]       w_mode;
   logic [PAT_W-1:0] r_sh_pat;
   logic [PAT_W-1:0] r_act_pat;
   logic [PAT_W-1:0] w_sh_pat;
   logic [PAT_W-1:0] w_pat;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_k;
   logic [CW-1:0]    w_cnt_nxt;
   logic [CW:0]      w_idx;
   logic [LANES-1:0] r_serial;
   logic [LANES-1:0] w_bits;
   logic             r_fs;
   logic             w_at_zero;
   logic             w_bnd;
   logic             w_emit;

   function automatic logic [1:0] norm_mode(input logic [1:0] m);
`ifdef TEST_PATTERN_GEN_PRBS_EN
      return m;
`else
      return m[1] ? 2'd0 : m;
`endif
   endfunction

   // A load in the same cycle as a boundary (or enable rising) governs that frame.
   assign w_sh_mode = load ? norm_mode(mode) : r_sh_mode;
   assign w_sh_pat  = load ? pattern : r_sh_pat;

`ifdef TEST_PATTERN_GEN_PRBS_EN
   logic [6:0]  r_lfsr7;
   logic [6:0]  w_l7;
   logic [14:0] r_lfsr15;
   logic [14:0] w_l15;

   // PRBS frames end when the register has cycled back to the all-ones seed.
   always_comb begin
      w_at_zero = 1'b0;
      case (r_act_mode)
         2'd2:    w_at_zero = (r_lfsr7 == '1);
         2'd3:    w_at_zero = (r_lfsr15 == '1);
         default: w_at_zero = (r_cnt == '0);
      endcase
   end

   assign w_l7  = w_bnd ? '1 : r_lfsr7;
   assign w_l15 = w_bnd ? '1 : r_lfsr15;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_lfsr7  <= '1;
         r_lfsr15 <= '1;
      end else if (!w_emit) begin
         r_lfsr7  <= '1;
         r_lfsr15 <= '1;
      end else begin
         r_lfsr7  <= (w_mode == 2'd2) ? {w_l7[5:0], w_l7[6] ^ w_l7[5]} : '1;
         r_lfsr15 <= (w_mode == 2'd3) ? {w_l15[13:0], w_l15[14] ^ w_l15[13]} : '1;
      end
   end
`else
   logic w_unused_inv;
   assign w_unused_inv = ^LANE_INV;
   assign w_at_zero    = (r_cnt == '0);
`endif

   assign w_bnd = (r_state == S_IDLE) | w_at_zero;

   // Dropping enable exactly on a frame end goes straight back to IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (enable) w_state_nxt = S_RUN;
         S_RUN:  if (!enable) w_state_nxt = w_bnd ? S_IDLE : S_STOP;
         S_STOP: begin
            if (enable)     w_state_nxt = S_RUN;
            else if (w_bnd) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_emit    = (w_state_nxt != S_IDLE);
   assign w_mode    = w_bnd ? w_sh_mode : r_act_mode;
   assign w_pat     = w_bnd ? w_sh_pat : r_act_pat;
   assign w_k       = w_bnd ? '0 : r_cnt;
   assign w_cnt_nxt = (w_k == CW'(PAT_W - 1)) ? '0 : w_k + CW'(1);

   always_comb begin
      w_bits = '0;
      w_idx  = '0;
      for (int i = 0; i < LANES; i++) begin
         w_idx = {1'b0, w_k} + (CW+1)'(i % PAT_W);
         if (w_idx >= (CW+1)'(PAT_W)) w_idx = w_idx - (CW+1)'(PAT_W);
         case (w_mode)
            2'd1:    w_bits[i] = (w_idx == '0);
`ifdef TEST_PATTERN_GEN_PRBS_EN
            2'd2:    w_bits[i] = w_l7[6] ^ LANE_INV[i];
            2'd3:    w_bits[i] = w_l15[14] ^ LANE_INV[i];
`endif
            default: w_bits[i] = w_pat[w_idx[CW-1:0]];
         endcase
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_state    <= S_IDLE;
         r_sh_mode  <= '0;
         r_act_mode <= '0;
         r_sh_pat   <= '0;
         r_act_pat  <= '0;
         r_cnt      <= '0;
         r_serial   <= '0;
         r_fs       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (load) begin
            r_sh_mode <= norm_mode(mode);
            r_sh_pat  <= pattern;
         end
         if (w_bnd) begin
            r_act_mode <= w_sh_mode;
            r_act_pat  <= w_sh_pat;
         end
         if (!w_emit) begin
            r_serial <= '0;
            r_fs     <= 1'b0;
            r_cnt    <= '0;
         end else begin
            r_serial <= w_bits;
            r_fs     <= w_bnd;
            r_cnt    <= w_mode[1] ? '0 : w_cnt_nxt;
         end
      end
   end

   assign serial_out  = r_serial;
   assign frame_start = r_fs;
   assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_test_pattern_gen.sv
// Bench for test_pattern_gen: two instances (32-bit/4-lane and 8-bit/16-lane) share stimulus
// and are compared every cycle against a frame-level model; literal checks pin that model.
module tb_test_pattern_gen;
   localparam int ST_IDLE = 0;
   localparam int ST_RUN  = 1;
   localparam int ST_STOP = 2;

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic        enable = 1'b0;
   logic        load = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [63:0] pattern = '0;
   logic [3:0]  ser_a;
   logic        fs_a, busy_a;
   logic [15:0] ser_b;
   logic        fs_b, busy_b;

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   always #5 clk = ~clk;

   test_pattern_gen #(.LANES(4), .PAT_W(32), .LANE_INV(4'b0010)) u_a (
      .clk(clk), .aresetn(aresetn), .enable(enable), .load(load), .mode(mode),
      .pattern(pattern[31:0]), .serial_out(ser_a), .frame_start(fs_a), .busy(busy_a)
   );

   test_pattern_gen #(.LANES(16), .PAT_W(8), .LANE_INV(16'hA5C3)) u_b (
      .clk(clk), .aresetn(aresetn), .enable(enable), .load(load), .mode(mode),
      .pattern(pattern[7:0]), .serial_out(ser_b), .frame_start(fs_b), .busy(busy_b)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   bit          prbs7_seq[127];
   bit          prbs15_seq[32767];
   int          pw[2]       = '{32, 8};
   int          nl[2]       = '{4, 16};
   logic [15:0] inv_mask[2] = '{16'h0002, 16'hA5C3};
   int          m_state[2], m_k[2], m_sh_mode[2], m_act_mode[2];
   logic [63:0] m_sh_pat[2], m_act_pat[2];
   logic [15:0] m_ser[2];
   logic        m_fs[2], m_busy[2];
   logic [17:0] exp_q_a[$];
   logic [17:0] exp_q_b[$];

   function automatic int norm_mode(input int m);
`ifdef TEST_PATTERN_GEN_PRBS_EN
      return m;
`else
      return (m >= 2) ? 0 : m;
`endif
   endfunction

   function automatic int frame_len(input int md, input int w);
      if (md == 2) return 127;
      if (md == 3) return 32767;
      return w;
   endfunction

   function automatic logic model_bit(input int md, input logic [63:0] pat, input int w,
                                      input int k, input int lane, input logic inv);
      case (md)
         1:       return ((k + lane) % w) == 0;
         2:       return prbs7_seq[k] ^ inv;
         3:       return prbs15_seq[k] ^ inv;
         default: return pat[(k + lane) % w];
      endcase
   endfunction

   task automatic model_clear(input int j);
      m_state[j] = ST_IDLE; m_k[j] = 0;
      m_sh_mode[j] = 0; m_act_mode[j] = 0; m_sh_pat[j] = '0; m_act_pat[j] = '0;
      m_ser[j] = '0; m_fs[j] = 1'b0; m_busy[j] = 1'b0;
   endtask

   task automatic model_step(input int j);
      int nxt;
      bit fend;
      if (load) begin
         m_sh_mode[j] = norm_mode(int'(mode));
         m_sh_pat[j]  = pattern & ((64'd1 << pw[j]) - 64'd1);
      end
      fend = (m_state[j] == ST_IDLE) || (m_k[j] == frame_len(m_act_mode[j], pw[j]) - 1);
      if (m_state[j] == ST_IDLE) nxt = enable ? ST_RUN : ST_IDLE;
      else                       nxt = enable ? ST_RUN : (fend ? ST_IDLE : ST_STOP);
      if (fend) begin
         m_act_mode[j] = m_sh_mode[j];
         m_act_pat[j]  = m_sh_pat[j];
      end
      if (nxt == ST_IDLE) begin
         m_ser[j] = '0; m_fs[j] = 1'b0; m_busy[j] = 1'b0; m_k[j] = 0;
      end else begin
         m_k[j] = fend ? 0 : m_k[j] + 1;
         m_ser[j] = '0;
         for (int i = 0; i < nl[j]; i++)
            m_ser[j][i] = model_bit(m_act_mode[j], m_act_pat[j], pw[j], m_k[j], i, inv_mask[j][i]);
         m_fs[j] = (m_k[j] == 0);
         m_busy[j] = 1'b1;
      end
      m_state[j] = nxt;
   endtask

   always @(posedge clk) begin
      for (int j = 0; j < 2; j++) begin
         if (!aresetn) model_clear(j);
         else model_step(j);
      end
      exp_q_a.push_back({m_busy[0], m_fs[0], m_ser[0]});
      exp_q_b.push_back({m_busy[1], m_fs[1], m_ser[1]});
   end

   // ---------------- per-cycle scoreboard compare ----------------
   always @(posedge clk) begin
      logic [17:0] e;
      #1;
      if (exp_q_a.size() > 0) begin
         e = exp_q_a.pop_front();
         if (cmp_en) check("cycle_a", {busy_a, fs_a, 12'd0, ser_a}, e);
      end
      if (exp_q_b.size() > 0) begin
         e = exp_q_b.pop_front();
         if (cmp_en) check("cycle_b", {busy_b, fs_b, ser_b}, e);
      end
   end

   // ---------------- driver helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fs_a(input int lim, output int n);
      n = 0;
      while (!fs_a && n < lim) begin tick(); n++; end
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      int n, gap, r;
      logic [7:0]   v0, v1, v2;
      logic [15:0]  w0;
      logic [126:0] s0, s1;

      for (int i = 0; i < 127; i++)
         prbs7_seq[i] = (i < 7) ? 1'b1 : prbs7_seq[i-7] ^ prbs7_seq[i-6];
      for (int i = 0; i < 32767; i++)
         prbs15_seq[i] = (i < 15) ? 1'b1 : prbs15_seq[i-15] ^ prbs15_seq[i-14];
      for (int j = 0; j < 2; j++) model_clear(j);

      repeat (3) @(posedge clk);
      #1;
      check("rst_ser_a", ser_a, 0);
      check("rst_fs_a", fs_a, 0);
      check("rst_busy_a", busy_a, 0);
      check("rst_ser_b", ser_b, 0);
      aresetn = 1'b1;
      cmp_en  = 1'b1;
      tick();

      // fixed pattern, load together with enable rising
      load = 1'b1; mode = 2'd0; pattern = 64'hAA550FF0; enable = 1'b1;
      tick();
      load = 1'b0;
      check("first_fs_a", fs_a, 1);
      for (int k = 0; k < 8; k++) begin
         v0[k] = ser_a[0];
         v1[k] = ser_a[1];
         if (k < 7) tick();
      end
      check("fixed_lane0", v0, 8'hF0);
      check("fixed_lane1", v1, 8'hF8);
      n = 0; gap = -1;
      for (int i = 1; i <= 64; i++) begin
         tick();
         if (fs_a) begin n++; if (gap < 0) gap = i; end
      end
      check("fs_first_gap", gap, 25);
      check("fs_count_64", n, 2);

      // load walking-one at frame bit 10
      wait_fs_a(100, n);
      check("sync_fs_a", fs_a, 1);
      repeat (10) tick();
      load = 1'b1; mode = 2'd1;
      tick();
      load = 1'b0;
      wait_fs_a(100, n);
      check("walk_switch_delay", n, 21);
      check("walk_first_bits_a", ser_a, 4'b0001);

      // walking one on the 8-bit instance
      n = 0;
      while (!fs_b && n < 100) begin tick(); n++; end
      check("sync_fs_b", fs_b, 1);
      for (int k = 0; k < 8; k++) begin
         v0[k] = ser_b[0];
         v2[k] = ser_b[2];
         if (k < 7) tick();
      end
      check("walk_b_lane0", v0, 8'h01);
      check("walk_b_lane2", v2, 8'h40);

      // enable dropped mid-frame finishes the frame
      wait_fs_a(100, n);
      repeat (5) tick();
      enable = 1'b0;
      n = 0;
      while (busy_a && n < 100) begin tick(); n++; end
      check("stop_drain_cycles", n, 27);
      check("stop_idle_ser", ser_a, 0);
      check("stop_idle_fs", fs_a, 0);

      // re-raise while stopping: no gap
      enable = 1'b1;
      tick();
      check("restart_fs", fs_a, 1);
      repeat (5) tick();
      enable = 1'b0;
      gap = 0;
      for (int i = 0; i < 15; i++) begin tick(); if (!busy_a) gap++; end
      enable = 1'b1;
      n = 0;
      while (!fs_a && n < 100) begin tick(); n++; if (!busy_a) gap++; end
      check("reraise_frame_end", n, 12);
      check("reraise_no_gap", gap, 0);

      // asynchronous reset mid-frame
      wait_fs_a(100, n);
      repeat (12) tick();
      #1 aresetn = 1'b0;
      #1;
      check("async_rst_ser_a", ser_a, 0);
      check("async_rst_fs_a", fs_a, 0);
      check("async_rst_busy_a", busy_a, 0);
      check("async_rst_ser_b", ser_b, 0);
      repeat (2) tick();
      #1 aresetn = 1'b1;
      tick();
      check("post_rst_fs", fs_a, 1);
      check("post_rst_busy", busy_a, 1);
      check("post_rst_ser", ser_a, 0);

      enable = 1'b0;
      n = 0;
      while (busy_a && n < 100) begin tick(); n++; end
      check("idle_before_mode2", busy_a, 0);
      load = 1'b1; mode = 2'd2; pattern = 64'hAA550FF0; enable = 1'b1;
      tick();
      load = 1'b0;
`ifdef TEST_PATTERN_GEN_PRBS_EN
      for (int k = 0; k < 127; k++) begin
         s0[k] = ser_a[0];
         s1[k] = ser_a[1];
         tick();
      end
      check("prbs7_period_fs", fs_a, 1);
      check("prbs7_period_bit", ser_a[0], 1);
      check("prbs7_first7", s0[6:0], 7'h7F);
      check("prbs7_bit7", s0[7], 0);
      check("prbs7_ones", $countones(s0), 64);
      check("prbs7_lane1_inv", (s1 == ~s0), 1);
      load = 1'b1; mode = 2'd3;
      tick();
      load = 1'b0;
      wait_fs_a(200, n);
      check("prbs15_sync", fs_a, 1);
      for (int k = 0; k < 16; k++) begin w0[k] = ser_a[0]; tick(); end
      check("prbs15_first16", w0, 16'h7FFF);
      n = 0;
      while (!fs_a && n < 40000) begin tick(); n++; end
      check("prbs15_period", n, 32751);
`else
      for (int k = 0; k < 8; k++) begin
         v0[k] = ser_a[0];
         if (k < 7) tick();
      end
      check("mode2_as_fixed", v0, 8'hF0);
`endif

      // randomized traffic against the model
      tick();
      #1 aresetn = 1'b0;
      tick();
      #1 aresetn = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         tick();
         #1;
         aresetn = ($urandom_range(0, 399) != 0);
         enable  = ($urandom_range(0, 99) < 85);
         load    = ($urandom_range(0, 9) == 0);
         r = $urandom_range(0, 19);
         mode    = (r < 9) ? 2'd0 : (r < 17) ? 2'd1 : (r < 19) ? 2'd2 : 2'd3;
         pattern = {$urandom(), $urandom()};
      end
      aresetn = 1'b1; enable = 1'b0; load = 1'b0;
      repeat (5) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1500000;
      n_checks++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/test_pattern_gen.md
TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

Interface
REQ-001 SHALL have parameter LANES, default 4, number of serial output lanes (1..16).
REQ-002 SHALL have parameter PAT_W, default 32, fixed/walking pattern length in bits (2..64, any integer).
REQ-003 SHALL have parameter LANE_INV, default 0, LANES-bit mask; set bit inverts that lane in PRBS modes.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  run request, level-sensitive.
REQ-007 SHALL have port load  input  1  one-cycle strobe capturing mode and pattern into shadow registers.
REQ-008 SHALL have port mode  input  2  0 fixed, 1 walking-one, 2 PRBS7, 3 PRBS15.
REQ-009 SHALL have port pattern  input  PAT_W  fixed-mode pattern, transmitted LSB first.
REQ-010 SHALL have port serial_out  output  LANES  registered NRZ lane data.
REQ-011 SHALL have port frame_start  output  1  high during the cycle serial_out carries bit 0 of a frame.
REQ-012 SHALL have port busy  output  1  high while state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, RUN, STOP; IDLE->RUN on enable=1; RUN->STOP on enable=0; STOP->IDLE at frame end; STOP->RUN if enable=1 before frame end.
REQ-014 SHALL drive bit 0 of the first frame on serial_out in the cycle after the edge that samples enable=1 in IDLE, with frame_start=1 that cycle.
REQ-015 SHALL, in fixed mode, drive lane i at frame bit k with pattern_active[(k+i) mod PAT_W].
REQ-016 SHALL, in walking-one mode, drive lane i at bit k with 1 when (k+i) mod PAT_W = 0, else 0.
REQ-017 SHALL use a bit counter of $clog2(PAT_W) bits wrapping from PAT_W-1 to 0; frame length PAT_W in modes 0/1.
REQ-018 SHALL, in PRBS7, use x^7+x^6+1, seed all ones, output LFSR MSB, shift left with MSB^(MSB-1) into bit 0; frame length 127.
REQ-019 SHALL, in PRBS15, use x^15+x^14+1, same structure and seed; frame length 32767.
REQ-020 SHALL drive identical PRBS bits on all lanes, XORed with LANE_INV[i].
REQ-021 SHALL apply shadow mode/pattern immediately in IDLE, and only at a frame boundary (next bit 0) in RUN/STOP; a later load before the boundary overwrites the earlier one.
REQ-022 SHALL reseed LFSR and clear bit counter at every mode change and on entry to RUN from IDLE.
REQ-023 SHALL hold serial_out=0 and frame_start=0 in IDLE.
REQ-024 SHALL accept load in the same cycle as enable rising; the new values govern the first frame.

Reset
REQ-025 SHALL, on aresetn=0, asynchronously force state IDLE, serial_out=0, frame_start=0, busy=0, counter 0, LFSR all ones, shadow/active mode 0, shadow/active pattern 0.
REQ-026 SHALL abort any frame immediately on reset mid-operation; no boundary completion.
REQ-027 SHALL require enable re-sampled high after reset release before RUN.

Configuration
REQ-028 SHALL compile PRBS modes only when macro TEST_PATTERN_GEN_PRBS_EN is defined.
REQ-029 SHALL, without TEST_PATTERN_GEN_PRBS_EN, omit both LFSRs and treat mode 2 and 3 as mode 0; LANE_INV has no effect.

Verification
REQ-030 SHALL verify: PAT_W=32, load pattern 0xAA550FF0 mode 0, enable=1 -> lane0 bits 0..7 = 0,0,0,0,1,1,1,1; lane1 = 0,0,0,1,1,1,1,1; frame_start every 32 cycles.
REQ-031 SHALL verify: PAT_W=8 mode 1 -> lane0 1,0,0,0,0,0,0,0 repeating; lane2 first bit 0, bit 6 = 1.
REQ-032 SHALL verify: mode 2, LANE_INV=4'b0010 -> lane0 first 7 bits 1, then 0; period 127; 64 ones per period; lane1 complement of lane0.
REQ-033 SHALL verify: load mode 1 at frame bit 10 of mode 0 -> mode 0 continues through bit 31; walking-one starts with frame_start.
REQ-034 SHALL verify: enable dropped at bit 5 -> busy stays 1 to bit 31, then serial_out=0, busy=0; re-raise at bit 20 -> no gap.
REQ-035 SHALL verify: aresetn low at bit 12 -> outputs 0 without waiting for a clock edge; resumes at bit 0 after reset release and enable.
